// File: rtl/timer_arbiter.sv
// timer_arbiter: two requesters share one interval counter under
// round-robin arbitration. The winner's length is captured at grant time,
// the counter runs from 0 up to that length, and a one-cycle done pulse
// goes to the owner before the arbiter returns to IDLE for at least one cycle.
module timer_arbiter #(
    parameter int unsigned NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [NUM_BITS-1:0] len0,
    input  logic [NUM_BITS-1:0] len1,
    input  logic                abort,
    output logic [1:0]          grant,
    output logic [1:0]          done,
    output logic                busy,
    output logic [NUM_BITS-1:0] count_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic                ptr;
    logic [NUM_BITS-1:0] len_q;

    logic                win;
    logic [1:0]          win_grant;
    logic [NUM_BITS-1:0] win_len;
    logic [NUM_BITS-1:0] cnt_inc;

    // Arbitration: a lone requester wins, otherwise the round-robin pointer decides
    always_comb begin
        win       = (req[0] & req[1]) ? ptr : req[1];
        win_grant = win ? 2'b10 : 2'b01;
        win_len   = win ? len1 : len0;
        cnt_inc   = count_out + NUM_BITS'(1);
    end

    // Interval FSM with registered grant/done/busy/count outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            count_out <= '0;
            ptr       <= 1'b0;
            len_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (req != 2'b00) begin
                        grant     <= win_grant;
                        len_q     <= win_len;
                        count_out <= '0;
                        busy      <= 1'b1;
                        // A zero-length interval skips counting; done is raised
                        // together with grant so it appears in the first grant cycle.
                        if (win_len != '0) begin
                            state <= COUNT;
                        end else begin
                            state <= DONE;
                            done  <= win_grant;
                        end
                    end
                end
                COUNT: begin
                    if (abort) begin
                        state     <= IDLE;
                        grant     <= '0;
                        done      <= '0;
                        busy      <= 1'b0;
                        count_out <= '0;
                        ptr       <= grant[0];
                    end else begin
                        count_out <= cnt_inc;
                        // done is registered, so it is set on the edge entering DONE
                        if (cnt_inc == len_q) begin
                            state <= DONE;
                            done  <= grant;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    grant     <= '0;
                    done      <= '0;
                    busy      <= 1'b0;
                    count_out <= '0;
                    // Point at the requester that was not just served
                    ptr       <= grant[0];
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    done      <= '0;
                    busy      <= 1'b0;
                    count_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter NUM_BITS, default 4, giving the width of interval lengths and count_out.
REQ-002 SHALL have port clk  input  1  rising-edge system clock; the single clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  2  level request per requester; bit k = requester k; held until granted.
REQ-005 SHALL have port len0  input  NUM_BITS  interval length for requester 0.
REQ-006 SHALL have port len1  input  NUM_BITS  interval length for requester 1.
REQ-007 SHALL have port abort  input  1  cancels the interval in progress.
REQ-008 SHALL have port grant  output  2  one-hot owner of the shared counter; 00 when idle.
REQ-009 SHALL have port done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port count_out  output  NUM_BITS  current value of the shared interval counter.

Function
REQ-012 SHALL implement FSM states IDLE, COUNT and DONE, plus a 1-bit round-robin pointer ptr.
REQ-013 In IDLE with req != 00, the edge SHALL set grant to the winner and latch the winner's len into len_q.
  - Single request: that requester wins.
  - Both requesting: requester ptr wins.
REQ-014 At that edge, state SHALL go to COUNT if the latched len is nonzero, else DONE; count_out SHALL be 0.
REQ-015 In COUNT, each edge SHALL increment count_out by 1.
  - The edge on which count_out becomes len_q SHALL move state to DONE.
REQ-016 In DONE, done[k] SHALL be high for exactly that cycle for the granted k; grant SHALL stay high.
REQ-017 The edge leaving DONE SHALL:
  - go to IDLE;
  - clear grant;
  - set count_out to 0;
  - set ptr to the index not just served.
REQ-018 Resulting latency:
  - done rises len cycles after grant rises; grant is high len+1 cycles.
  - len=0 gives done in the first grant cycle, with count_out held at 0.
REQ-019 IDLE SHALL last at least one cycle between grants (busy low at least 1 cycle); no back-to-back DONE-to-COUNT.
REQ-020 len0/len1 changes after the grant edge SHALL be ignored; only len_q is used.
REQ-021 abort in COUNT: next edge SHALL go to IDLE, clear grant, zero count_out, issue no done pulse, and advance ptr as in REQ-017.
REQ-022 abort SHALL be ignored in IDLE and DONE.
REQ-023 Dropping req while granted SHALL have no effect; only abort cancels.
REQ-024 Counting SHALL be unsigned with no wrap: count_out never exceeds len_q.
  - len = 2^NUM_BITS-1 SHALL complete normally.
REQ-025 grant SHALL never have more than one bit set, and done SHALL be set only where grant is set.

Reset
REQ-026 rst high at an edge SHALL force state IDLE, grant=00, done=00, busy=0, count_out=0, ptr=0 (requester 0 favoured).
REQ-027 rst SHALL take priority over req and abort.
  - A reset mid-interval SHALL produce no done pulse.
  - Normal operation resumes on the first edge with rst low.

Verification
REQ-028 The bench SHALL cover these directed scenarios (NUM_BITS=4):
  - Reset: rst high 2 edges, then low with req=00 -> grant=00, done=00, busy=0, count_out=0 on every cycle.
  - Single request: req=01, len0=5 -> grant=01 after next edge; count_out 0,1,2,3,4,5; done=01 for one cycle 5 cycles after grant rises; grant high 6 cycles; then IDLE.
  - Contention: req=11, len0=3, len1=4 held -> order 01, 10, 01; each grant separated by one IDLE cycle; done pulses at 3 and 4 cycles respectively.
  - Zero length: len1=0, req=10 -> grant=10 and done=10 in the same cycle; count_out stays 0.
  - Abort: len0=7, abort at count_out=2 with req=11 -> grant=00 next edge, no done; next grant is 10.
  - Reset and maximum length:
    - rst asserted at count_out=3 -> all outputs 0 next edge, no done.
    - len0=15, len0 changed to 2 mid-count -> done still after 15 cycles.
